cmp_stream_tracker: RTL and testbench
=====================================

# cmp_stream_tracker

Sequential front end for the ripple magnitude comparator. It accepts operand pairs over a valid/ready handshake and registers them. It evaluates each pair through one `comparator` instance, presents a one-hot greater/less/equal result over a second handshake, and keeps running statistics: per-outcome counts and the maximum operand seen. It sits directly upstream of the comparator and is the only block that drives its inputs.

## Interface
- `N`, default 4: operand width; passed unchanged to the `comparator` instance.
- `CNT_W`, default 8: width of each outcome counter.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clear` input 1: synchronous clear of statistics only.
- `in_valid` input 1: an operand pair is offered.
- `in_ready` output 1: the block can accept a pair.
- `in_a` input N: operand A.
- `in_b` input N: operand B.
- `out_valid` output 1: a result is presented.
- `out_ready` input 1: the consumer accepts the result.
- `out_gt` output 1: A > B.
- `out_lt` output 1: A < B.
- `out_eq` output 1: A == B.
- `max_val` output N: largest A or B accepted since the last reset or clear.
- `gt_cnt` output CNT_W: number of consumed GT results.
- `lt_cnt` output CNT_W: number of consumed LT results.
- `eq_cnt` output CNT_W: number of consumed EQ results.

## Operation
- The FSM has three states: IDLE, EVAL, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` && `in_ready`, register `in_a` and `in_b` into `a_q` and `b_q`, then go to EVAL.
- EVAL:
  - `in_ready`=0.
  - `a_q` and `b_q` drive the comparator.
  - The final result is taken from bit 0 of the comparator outputs: `gt = gout[0] & ~lout[0]`, `lt = lout[0] & ~gout[0]`, `eq = ~gout[0] & ~lout[0]`.
  - Register the result into `out_gt`, `out_lt`, `out_eq`.
  - Update `max_val` with the larger of `a_q` and `b_q`. The ordering is decided from the same result (use B when lt, otherwise A), not from a separate `>`.
  - Go to HOLD.
- HOLD:
  - `out_valid`=1.
  - Outputs stay stable until `out_valid` && `out_ready`.
  - On that handshake, increment exactly one counter and go to IDLE.
- Exactly one of `out_gt`, `out_lt`, `out_eq` is set whenever `out_valid`=1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `max_val` comparison is unsigned.
- `clear`:
  - Zeroes all three counters and `max_val`.
  - Does not affect the FSM, `a_q`/`b_q`, or the result outputs.
  - If `clear` coincides with a counter increment or a `max_val` update, `clear` wins and that transaction is not recorded.
- `reset` takes priority over everything:
  - State goes to IDLE.
  - `out_valid`, `out_gt`, `out_lt`, `out_eq` go to 0.
  - Counters go to 0; `max_val` goes to 0; `a_q`/`b_q` go to 0.
- Reset in EVAL or HOLD drops the in-flight pair with no count.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, result bits 0, counters 0, `max_val` 0.
- Latency: with a pair accepted at edge k, `out_valid`=1 from edge k+2.
- The counter reflects the result on the cycle after the output handshake.
- Throughput is at most one pair per 3 cycles, with `out_ready` held high.
- `in_ready` depends on state only, never on `in_valid`.
- `out_valid` is a registered state decode with no combinational path from `out_ready`.
- `in_valid` while not ready is ignored; the source must hold its data until the handshake.
- Back-pressure: the block holds in HOLD indefinitely while `out_ready`=0.

## Structure
- Package `cmp_pkg` holds:
  - the `state_t` enum {IDLE, EVAL, HOLD};
  - the `cmp_res_t` packed struct {gt, lt, eq};
  - a function decoding `gout[0]`/`lout[0]` into a `cmp_res_t`.
- One sub-module: the existing `comparator #(.N(N))`, instantiated once.
- No other hierarchy.

## Test plan
- Reset, then A=4'b1010, B=4'b0011 with `out_ready`=1 → `out_gt`=1 at k+2, `gt_cnt`=1, `max_val`=4'b1010.
- A=4'b0111, B=4'b0111 → `out_eq`=1, `eq_cnt`=1; A=0, B=4'b1111 → `out_lt`=1, `max_val`=4'b1111.
- Hold `out_ready`=0 for 5 cycles in HOLD:
  - outputs stay stable and `in_ready`=0;
  - a new `in_valid` pair is not taken;
  - count increments once, after release.
- CNT_W=2, five GT pairs → `gt_cnt` saturates at 3.
- `clear` asserted on the same cycle as the HOLD handshake → all counters and `max_val` read 0 afterwards; the FSM still returns to IDLE.
- `reset` asserted in EVAL → next cycle IDLE, `out_valid`=0, all counters 0. The next pair completes normally with 2-cycle latency.
- Random 1000 pairs checked against a behavioural `>`/`<` model:
  - exactly one result bit set;
  - counts sum equals the number of handshakes.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the comparator stream tracker: FSM states and one-hot result.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Bit 0 of the ripple outputs carries the full-width decision.
  function automatic cmp_res_t decode_res(input logic g0, input logic l0);
    cmp_res_t r;
    r.gt = g0 & ~l0;
    r.lt = l0 & ~g0;
    r.eq = ~g0 & ~l0;
    return r;
  endfunction

endpackage

// File: rtl/comparator.sv
// Ripple magnitude comparator, MSB to LSB; tap i decides on bits N-1..i.
// Latency: combinational.
// Backpressure: none.
module comparator #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] gout,
  output logic [N-1:0] lout
);

  // Once a higher bit has decided greater/less, lower bits cannot change it.
  always_comb begin : ripple
    logic g, l, gn, ln;
    gout = '0;
    lout = '0;
    g    = 1'b0;
    l    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      gn      = g | (~l & a[i] & ~b[i]);
      ln      = l | (~g & ~a[i] & b[i]);
      g       = gn;
      l       = ln;
      gout[i] = g;
      lout[i] = l;
    end
  end

endmodule

// File: rtl/cmp_stream_tracker.sv
// Registers operand pairs, compares them, presents a one-hot result and keeps outcome/max statistics.
// Latency: pair accepted at edge k is presented (out_valid=1) for sampling at edge k+2; one pair per 3 cycles max.
// Backpressure: holds the result indefinitely while out_ready=0; in_ready is low outside IDLE.
module cmp_stream_tracker
  import cmp_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_lt,
  output logic             out_eq,
  output logic [N-1:0]     max_val,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [N-1:0]   gout, lout;
  cmp_res_t       res_now, res_q;
  logic [N-1:0]   larger;
  logic           accept, eval, consume;

  comparator #(.N(N)) u_cmp (
    .a    (a_q),
    .b    (b_q),
    .gout (gout),
    .lout (lout)
  );

  // Only the LSB taps are used; the higher taps are partial decisions.
  wire unused_taps = ^{gout, lout};

  assign res_now = decode_res(gout[0], lout[0]);
  // Larger operand taken from the comparator result rather than a second magnitude compare.
  assign larger  = res_now.lt ? b_q : a_q;

  // Next-state and handshake decode; both ready and valid depend on state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    eval      = 1'b0;
    consume   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        eval    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand capture on the input handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  // Result register, loaded in EVAL and held through HOLD.
  always_ff @(posedge clk) begin
    if (reset)     res_q <= '0;
    else if (eval) res_q <= res_now;
  end

  assign out_gt = res_q.gt;
  assign out_lt = res_q.lt;
  assign out_eq = res_q.eq;

  // Statistics: clear beats any same-cycle update; counters saturate.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      max_val <= '0;
      gt_cnt  <= '0;
      lt_cnt  <= '0;
      eq_cnt  <= '0;
    end else begin
      if (eval && (larger > max_val)) max_val <= larger;
      if (consume) begin
        if (res_q.gt && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_ONE;
        if (res_q.lt && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_ONE;
        if (res_q.eq && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Bench for cmp_stream_tracker: vector table, hand corner sequences and random pairs vs a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cmp_stream_tracker;

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, out_ready;
  logic [3:0] in_a, in_b;

  logic       in_ready, out_valid, out_gt, out_lt, out_eq;
  logic [3:0] max_val;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;

  logic       s_in_ready, s_out_valid, s_out_gt, s_out_lt, s_out_eq;
  logic [3:0] s_max_val;
  logic [1:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_stream_tracker #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_lt(out_lt), .out_eq(out_eq),
    .max_val(max_val), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  cmp_stream_tracker #(.N(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_gt(s_out_gt), .out_lt(s_out_lt), .out_eq(s_out_eq),
    .max_val(s_max_val), .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] res;   // {gt, lt, eq}
    logic [3:0] mx;    // max_val after this pair
  } vec_t;

  vec_t tbl[5];

  int exp_g, exp_l, exp_e, exp_mx;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_stats(input string nm);
    check({nm, "_gt_cnt"}, 32'(gt_cnt), 32'(sat(exp_g, 255)));
    check({nm, "_lt_cnt"}, 32'(lt_cnt), 32'(sat(exp_l, 255)));
    check({nm, "_eq_cnt"}, 32'(eq_cnt), 32'(sat(exp_e, 255)));
    check({nm, "_max"},    32'(max_val), 32'(exp_mx));
    check({nm, "_sat_gt"}, 32'(s_gt_cnt), 32'(sat(exp_g, 3)));
    check({nm, "_sat_lt"}, 32'(s_lt_cnt), 32'(sat(exp_l, 3)));
    check({nm, "_sat_eq"}, 32'(s_eq_cnt), 32'(sat(exp_e, 3)));
  endtask

  task automatic model_pair(input logic [3:0] a, input logic [3:0] b);
    if (a > b)      exp_g++;
    else if (a < b) exp_l++;
    else            exp_e++;
    if (int'(a) > exp_mx) exp_mx = int'(a);
    if (int'(b) > exp_mx) exp_mx = int'(b);
  endtask

  task automatic clear_stats;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    exp_g = 0; exp_l = 0; exp_e = 0; exp_mx = 0;
  endtask

  // One full transaction: accept, latency check, optional stall, handshake.
  task automatic do_pair(input logic [3:0] a, input logic [3:0] b, input int stall,
                         output logic [2:0] res);
    int n;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin tick; n++; end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    tick;                                   // edge k: pair accepted
    in_valid = 1'b0;
    check("lat_k1_valid", 32'(out_valid), 32'd0);
    tick;                                   // edge k+1: result registered
    check("lat_k2_valid", 32'(out_valid), 32'd1);
    res = {out_gt, out_lt, out_eq};
    check("sat_inst_res", 32'({s_out_gt, s_out_lt, s_out_eq}), 32'(res));
    for (int i = 0; i < stall; i++) begin
      tick;
      check("stall_stable", 32'({in_ready, out_valid, out_gt, out_lt, out_eq}), 32'({2'b01, res}));
    end
    out_ready = 1'b1;
    tick;                                   // output handshake
    out_ready = 1'b0;
    model_pair(a, b);
    check("post_hs_idle", 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    logic [2:0] r;
    logic [3:0] ra, rb;
    int         bhs;

    tbl[0] = '{a: 4'b1010, b: 4'b0011, res: 3'b100, mx: 4'b1010};
    tbl[1] = '{a: 4'b0111, b: 4'b0111, res: 3'b001, mx: 4'b1010};
    tbl[2] = '{a: 4'b0000, b: 4'b1111, res: 3'b010, mx: 4'b1111};
    tbl[3] = '{a: 4'b0101, b: 4'b1001, res: 3'b010, mx: 4'b1111};
    tbl[4] = '{a: 4'b1111, b: 4'b1111, res: 3'b001, mx: 4'b1111};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    exp_g = 0; exp_l = 0; exp_e = 0; exp_mx = 0;
    tick; tick;
    check("rst_ready_valid", 32'({in_ready, out_valid}), 32'b10);
    check("rst_result", 32'({out_gt, out_lt, out_eq}), 32'd0);
    check_stats("rst");
    reset = 1'b0;
    tick;

    // Vector table, out_ready effectively high (no stall).
    for (int i = 0; i < 5; i++) begin
      do_pair(tbl[i].a, tbl[i].b, 0, r);
      check($sformatf("tbl%0d_res", i), 32'(r), 32'(tbl[i].res));
      check($sformatf("tbl%0d_max", i), 32'(max_val), 32'(tbl[i].mx));
      check_stats($sformatf("tbl%0d", i));
    end

    // Backpressure: 5 stalled cycles in HOLD with a competing pair offered.
    clear_stats;
    check_stats("clr_idle");
    in_a = 4'd3; in_b = 4'd9; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    check("bp_hold_lt", 32'({out_valid, out_gt, out_lt, out_eq}), 32'b1010);
    in_a = 4'd14; in_b = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_stable", 32'({in_ready, out_valid, out_gt, out_lt, out_eq}), 32'b01010);
      check("bp_no_count", 32'(lt_cnt), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    model_pair(4'd3, 4'd9);
    check("bp_release_idle", 32'({in_ready, out_valid}), 32'b10);
    check_stats("bp_release");
    tick;
    check("bp_not_taken", 32'({in_ready, out_valid}), 32'b10);
    check("bp_max_kept", 32'(max_val), 32'd9);

    // Saturation: five GT pairs; 2-bit counter stops at 3.
    clear_stats;
    for (int i = 0; i < 5; i++) begin
      do_pair(4'(8 + i), 4'(i), 0, r);
      check("sat_pair_gt", 32'(r), 32'b100);
    end
    check("sat_gt_cnt2", 32'(s_gt_cnt), 32'd3);
    check("sat_gt_cnt8", 32'(gt_cnt), 32'd5);
    check_stats("sat");

    // Clear coinciding with the output handshake: nothing recorded.
    in_a = 4'd6; in_b = 4'd2; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    check("clrhs_hold", 32'({out_valid, out_gt}), 32'b11);
    clear = 1'b1; out_ready = 1'b1;
    tick;
    clear = 1'b0; out_ready = 1'b0;
    exp_g = 0; exp_l = 0; exp_e = 0; exp_mx = 0;
    check("clrhs_idle", 32'({in_ready, out_valid}), 32'b10);
    check_stats("clrhs");

    // Reset while in EVAL drops the pair; the next pair completes normally.
    do_pair(4'd2, 4'd1, 0, r);
    check("pre_rst_gt", 32'(gt_cnt), 32'd1);
    in_a = 4'd12; in_b = 4'd5; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_g = 0; exp_l = 0; exp_e = 0; exp_mx = 0;
    check("evrst_idle", 32'({in_ready, out_valid}), 32'b10);
    check("evrst_result", 32'({out_gt, out_lt, out_eq}), 32'd0);
    check_stats("evrst");
    tick;
    check("evrst_no_resume", 32'(out_valid), 32'd0);
    do_pair(4'd4, 4'd11, 0, r);
    check("evrst_next_res", 32'(r), 32'b010);
    check_stats("evrst_next");

    // Random pairs with random stalls, checked against plain > / < arithmetic.
    clear_stats;
    bhs = 0;
    for (int p = 0; p < 1000; p++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      do_pair(ra, rb, int'($urandom_range(0, 3)), r);
      bhs++;
      check("rnd_res", 32'(r), 32'({ra > rb, ra < rb, ra == rb}));
      check("rnd_onehot", 32'($countones(r)), 32'd1);
      check("rnd_max", 32'(max_val), 32'(exp_mx));
      if ((p % 100) == 99) begin
        check_stats("rnd_batch");
        check("rnd_cnt_sum", 32'(gt_cnt) + 32'(lt_cnt) + 32'(eq_cnt), 32'(bhs));
        clear_stats;
        bhs = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
